// File: rtl/sbox_share_arbiter.sv
// Purpose: one shared 4-bit S-AES S-box, time-multiplexed between the round datapath (A, 16 bit)
//          and the key schedule (B, 8 bit); one nibble is substituted per clock.
// Latency: the response is valid from edge T+4 (A) or T+2 (B) after acceptance edge T.
// Backpressure: the response is held until rsp_ready. No request is accepted while busy,
//          and nothing is queued.
//
// Ports:
//   clk, rst_n                          clock; asynchronous active-low reset
//   a_req_valid/a_req_ready/a_req_data  round-state request, 16 bit
//   a_rsp_valid/a_rsp_ready/a_rsp_data  substituted round state, 16 bit
//   b_req_valid/b_req_ready/b_req_data  key-schedule request, 8 bit
//   b_rsp_valid/b_rsp_ready/b_rsp_data  substituted key byte, 8 bit
//   busy                                high whenever the FSM is not in IDLE
//   a_req_inv                           only with SBOX_INV_EN defined: selects the inverse table for A
//
// Build option: define SBOX_INV_EN to add the inverse S-box and the a_req_inv input.
// Port B always uses the forward table.

module sbox_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req_valid,
  input  logic [15:0] a_req_data,
`ifdef SBOX_INV_EN
  input  logic        a_req_inv,
`endif
  output logic        a_req_ready,
  output logic        a_rsp_valid,
  output logic [15:0] a_rsp_data,
  input  logic        a_rsp_ready,

  input  logic        b_req_valid,
  input  logic [7:0]  b_req_data,
  output logic        b_req_ready,
  output logic        b_rsp_valid,
  output logic [7:0]  b_rsp_data,
  input  logic        b_rsp_ready,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Forward S-AES nibble substitution.
  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h9;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'hB;
      4'h4: y = 4'hD;
      4'h5: y = 4'h1;
      4'h6: y = 4'h8;
      4'h7: y = 4'h5;
      4'h8: y = 4'h6;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'h3;
      4'hC: y = 4'hC;
      4'hD: y = 4'hE;
      4'hE: y = 4'hF;
      default: y = 4'h7;
    endcase
    return y;
  endfunction

`ifdef SBOX_INV_EN
  // Inverse S-AES nibble substitution.
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;
      4'h1: y = 4'h5;
      4'h2: y = 4'h9;
      4'h3: y = 4'hB;
      4'h4: y = 4'h1;
      4'h5: y = 4'h7;
      4'h6: y = 4'h8;
      4'h7: y = 4'hF;
      4'h8: y = 4'h6;
      4'h9: y = 4'h0;
      4'hA: y = 4'h2;
      4'hB: y = 4'h3;
      4'hC: y = 4'hC;
      4'hD: y = 4'h4;
      4'hE: y = 4'hD;
      default: y = 4'hE;
    endcase
    return y;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;        // nibble currently being substituted
  logic [2:0]  cnt_q, cnt_d;        // number of nibbles in this request (4 or 2)
  logic [15:0] work_q, work_d;      // request word, overwritten nibble by nibble
  logic        owner_b_q, owner_b_d;  // 1: current request belongs to B
  logic        last_b_q, last_b_d;    // 1: B was the last port served (resets to B)
`ifdef SBOX_INV_EN
  logic        inv_q, inv_d;        // current request uses the inverse table
`endif

  logic        grant_a;
  logic        grant_b;
  logic [3:0]  sub_in;
  logic [3:0]  sub_out;
  logic        last_nib;
  logic        rsp_fire;

  // Round-robin grant: a lone requester always wins. On a tie, the port
  // not served last wins.
  assign grant_a = a_req_valid && (!b_req_valid ||  last_b_q);
  assign grant_b = b_req_valid && (!a_req_valid || !last_b_q);

  assign a_req_ready = (state_q == S_IDLE) && grant_a;
  assign b_req_ready = (state_q == S_IDLE) && grant_b;

  // The single shared S-box. Its input nibble is selected by idx, LSB nibble first.
  assign sub_in = work_q[{idx_q, 2'b00} +: 4];
`ifdef SBOX_INV_EN
  assign sub_out = inv_q ? sbox_inv(sub_in) : sbox_fwd(sub_in);
`else
  assign sub_out = sbox_fwd(sub_in);
`endif

  assign last_nib = ({1'b0, idx_q} == (cnt_q - 3'd1));

  // Responses are decoded only from registered state, so the data holds
  // stable for as long as the consumer stalls.
  assign a_rsp_valid = (state_q == S_RESP) && !owner_b_q;
  assign b_rsp_valid = (state_q == S_RESP) &&  owner_b_q;
  assign a_rsp_data  = a_rsp_valid ? work_q : 16'h0000;
  assign b_rsp_data  = b_rsp_valid ? work_q[7:0] : 8'h00;
  assign busy        = (state_q != S_IDLE);

  assign rsp_fire = (a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
`ifdef SBOX_INV_EN
    inv_d     = inv_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (a_req_ready) begin
          work_d    = a_req_data;
          idx_d     = 2'd0;
          cnt_d     = 3'd4;
          owner_b_d = 1'b0;
`ifdef SBOX_INV_EN
          inv_d     = a_req_inv;
`endif
          state_d   = S_SUB;
        end else if (b_req_ready) begin
          work_d    = {8'h00, b_req_data};
          idx_d     = 2'd0;
          cnt_d     = 3'd2;
          owner_b_d = 1'b1;
`ifdef SBOX_INV_EN
          inv_d     = 1'b0;
`endif
          state_d   = S_SUB;
        end
      end

      S_SUB: begin
        work_d[{idx_q, 2'b00} +: 4] = sub_out;
        idx_d = idx_q + 2'd1;
        if (last_nib) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_fire) begin
          state_d  = S_IDLE;
          last_b_d = owner_b_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 3'd0;
      work_q    <= 16'h0000;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
`ifdef SBOX_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
`ifdef SBOX_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Purpose: directed bench for sbox_share_arbiter using a vector table plus hand sequences.
// Latency: drives inputs #1 after the rising edge and samples at #1 or at the falling edge.
// Backpressure: exercises a stalled response, tie arbitration and reset during SUB.

module tb_sbox_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req_valid;
  logic [15:0] a_req_data;
  logic        a_req_ready;
  logic        a_rsp_valid;
  logic [15:0] a_rsp_data;
  logic        a_rsp_ready;
  logic        b_req_valid;
  logic [7:0]  b_req_data;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic [7:0]  b_rsp_data;
  logic        b_rsp_ready;
  logic        busy;
`ifdef SBOX_INV_EN
  logic        a_req_inv;
`endif

  int n_checks;
  int n_fail;

  sbox_share_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req_valid (a_req_valid),
    .a_req_data  (a_req_data),
`ifdef SBOX_INV_EN
    .a_req_inv   (a_req_inv),
`endif
    .a_req_ready (a_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .a_rsp_ready (a_rsp_ready),
    .b_req_valid (b_req_valid),
    .b_req_data  (b_req_data),
    .b_req_ready (b_req_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_data  (b_rsp_data),
    .b_rsp_ready (b_rsp_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_b;
    logic [15:0] data;
    logic        inv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A single request with immediate acceptance, followed by the latency check,
  // the data check and the response handshake.
  task automatic run_req(input string nm, input logic is_b, input logic [15:0] data,
                         input logic inv, input logic [15:0] exp);
    int          lat;
    logic        early;
    logic        rv;
    logic        ov;
    logic [15:0] rd;
    lat = is_b ? 2 : 4;
    if (is_b) begin
      b_req_valid = 1'b1;
      b_req_data  = data[7:0];
    end else begin
      a_req_valid = 1'b1;
      a_req_data  = data;
    end
`ifdef SBOX_INV_EN
    a_req_inv = inv;
`endif
    @(negedge clk);
    check({nm, "_req_ready"}, {15'd0, is_b ? b_req_ready : a_req_ready}, 16'd1);
    @(posedge clk); #1;                       // acceptance edge T
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    check({nm, "_busy"}, {15'd0, busy}, 16'd1);
    early = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (a_rsp_valid || b_rsp_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    check({nm, "_early_valid"}, {15'd0, early}, 16'd0);
    rv = is_b ? b_rsp_valid : a_rsp_valid;
    ov = is_b ? a_rsp_valid : b_rsp_valid;
    rd = is_b ? {8'h00, b_rsp_data} : a_rsp_data;
    check({nm, "_rsp_valid"}, {15'd0, rv}, 16'd1);
    check({nm, "_other_valid"}, {15'd0, ov}, 16'd0);
    check({nm, "_rsp_data"}, rd, exp);
    if (is_b) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    @(posedge clk); #1;                       // handshake edge R
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    check({nm, "_valid_after_hs"}, {15'd0, a_rsp_valid | b_rsp_valid}, 16'd0);
    check({nm, "_idle_after_hs"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic seen;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    a_req_valid = 1'b0;
    a_req_data  = 16'h0000;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0;
    b_req_data  = 8'h00;
    b_rsp_ready = 1'b0;
`ifdef SBOX_INV_EN
    a_req_inv   = 1'b0;
`endif

    // Vector table: {is_b, data, inv, expected}
    vecs.push_back('{1'b0, 16'h1234, 1'b0, 16'h4ABD});
    vecs.push_back('{1'b1, 16'h005A, 1'b0, 16'h0010});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h9999});
    vecs.push_back('{1'b0, 16'hFFFF, 1'b0, 16'h7777});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 16'h0099});
    vecs.push_back('{1'b1, 16'h00FF, 1'b0, 16'h0077});
    vecs.push_back('{1'b0, 16'h0123, 1'b0, 16'h94AB});
    vecs.push_back('{1'b0, 16'h89AB, 1'b0, 16'h6203});
    vecs.push_back('{1'b1, 16'h003C, 1'b0, 16'h00BC});
    vecs.push_back('{1'b0, 16'hCDEF, 1'b0, 16'hCEF7});
`ifdef SBOX_INV_EN
    vecs.push_back('{1'b0, 16'h4ABD, 1'b1, 16'h1234});
    vecs.push_back('{1'b0, 16'hFFFF, 1'b0, 16'h7777});
    vecs.push_back('{1'b0, 16'h9999, 1'b1, 16'h0000});
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rsp_valid", {14'd0, a_rsp_valid, b_rsp_valid}, 16'd0);
    check("rst_a_rsp_data", a_rsp_data, 16'h0000);
    check("rst_b_rsp_data", {8'h00, b_rsp_data}, 16'h0000);
    check("rst_req_ready", {14'd0, a_req_ready, b_req_ready}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie from reset: A first, then alternating. Both requests stay valid.
    a_req_valid = 1'b1;
    a_req_data  = 16'h1234;
    b_req_valid = 1'b1;
    b_req_data  = 8'h5A;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check($sformatf("tie%0d_a_ready", g), {15'd0, a_req_ready}, (g % 2 == 0) ? 16'd1 : 16'd0);
      check($sformatf("tie%0d_b_ready", g), {15'd0, b_req_ready}, (g % 2 == 1) ? 16'd1 : 16'd0);
      @(posedge clk); #1;
      check($sformatf("tie%0d_ready_busy", g), {14'd0, a_req_ready, b_req_ready}, 16'd0);
      repeat ((g % 2 == 1) ? 2 : 4) @(posedge clk);
      #1;
      if (g % 2 == 1) begin
        check($sformatf("tie%0d_b_valid", g), {14'd0, a_rsp_valid, b_rsp_valid}, 16'd1);
        check($sformatf("tie%0d_b_data", g), {8'h00, b_rsp_data}, 16'h0010);
      end else begin
        check($sformatf("tie%0d_a_valid", g), {14'd0, a_rsp_valid, b_rsp_valid}, 16'd2);
        check($sformatf("tie%0d_a_data", g), a_rsp_data, 16'h4ABD);
      end
      @(posedge clk); #1;                     // handshake completes in one cycle
      check($sformatf("tie%0d_valid_1cyc", g), {14'd0, a_rsp_valid, b_rsp_valid}, 16'd0);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      run_req($sformatf("vec%0d%s", i, vecs[i].inv ? "i" : ""), vecs[i].is_b,
              vecs[i].data, vecs[i].inv, vecs[i].exp);
    end

    // Stalled A response while a B request is pending.
`ifdef SBOX_INV_EN
    a_req_inv = 1'b0;
`endif
    a_req_valid = 1'b1;
    a_req_data  = 16'h1234;
    @(negedge clk);
    check("bp_a_ready", {15'd0, a_req_ready}, 16'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b1;
    b_req_data  = 8'h5A;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_a_valid", k), {15'd0, a_rsp_valid}, 16'd1);
      check($sformatf("bp%0d_a_data", k), a_rsp_data, 16'h4ABD);
      check($sformatf("bp%0d_b_ready", k), {15'd0, b_req_ready}, 16'd0);
    end
    #4;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;                       // handshake edge R
    a_rsp_ready = 1'b0;
    check("bp_a_valid_after", {15'd0, a_rsp_valid}, 16'd0);
    check("bp_b_ready_after", {15'd0, b_req_ready}, 16'd1);
    @(posedge clk); #1;                       // B accepted at R+1
    b_req_valid = 1'b0;
    check("bp_b_busy", {15'd0, busy}, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_b_valid", {15'd0, b_rsp_valid}, 16'd1);
    check("bp_b_data", {8'h00, b_rsp_data}, 16'h0010);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;

    // Reset asserted while A is in SUB with idx = 2.
    a_req_valid = 1'b1;
    a_req_data  = 16'h1234;
    @(posedge clk); #1;                       // T
    a_req_valid = 1'b0;
    repeat (2) @(posedge clk);                // after T+2: idx = 2
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_a_valid", {15'd0, a_rsp_valid}, 16'd0);
    check("midrst_a_data", a_rsp_data, 16'h0000);
    check("midrst_ready", {14'd0, a_req_ready, b_req_ready}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_rsp_valid || busy) seen = 1'b1;
    end
    check("midrst_no_rsp", {15'd0, seen}, 16'd0);
    @(posedge clk); #1;
    run_req("postrst", 1'b0, 16'h0000, 1'b0, 16'h9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
